// File: rtl/posit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : posit_pkg
// Description : Shared widths, special encodings and handshake state enum for
//               the posit decoder / encoder pair.
// Revision    : 1.0 - initial release
// ============================================================================
package posit_pkg;

    localparam int N   = 32;
    localparam int ES  = 3;
    localparam int K_W = 6;

    localparam logic [31:0] MAXPOS  = 32'h7FFF_FFFF;
    localparam logic [31:0] MINPOS  = 32'h0000_0001;
    localparam logic [31:0] NAR_PAT = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REGIME = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/posit_round_rne.sv
`default_nettype none
// ============================================================================
// Module      : posit_round_rne
// Description : Round-to-nearest-even of the regime-shifted 64-bit body down
//               to a 31-bit payload, clamped at maxpos on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module posit_round_rne (
    input  logic [63:0] i_body,
    output logic [30:0] o_payload
);

    logic [30:0] w_trunc;
    logic        w_guard;
    logic        w_sticky;
    logic        w_inc;
    logic [31:0] w_sum;

    assign w_trunc  = i_body[63:33];
    assign w_guard  = i_body[32];
    assign w_sticky = |i_body[31:0];
    assign w_inc    = w_guard & (w_trunc[0] | w_sticky);
    assign w_sum    = {1'b0, w_trunc} + {31'b0, w_inc};

    // A carry out of bit 30 would spill into the sign position; pin to maxpos.
    assign o_payload = w_sum[31] ? 31'h7FFF_FFFF : w_sum[30:0];

endmodule
`default_nettype wire

// File: rtl/posit_encoder.sv
`default_nettype none
// ============================================================================
// Module      : posit_encoder
// Description : Packs sign/k/exponent/mantissa fields into a 32-bit es=3 posit,
//               inserting regime bits serially and rounding to nearest-even.
// Revision    : 1.0 - initial release
// ============================================================================
module posit_encoder
    import posit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             received,
    input  logic             sign,
    input  logic [K_W-1:0]   k,
    input  logic [ES-1:0]    exp_value,
    input  logic [31:0]      mantissa,
    input  logic             ZERO,
    input  logic             NAR,
    output logic [N-1:0]     posit_out,
    output logic             done,
    output logic             busy
);

    state_t      r_state;
    logic [63:0] r_body;
    logic [4:0]  r_cnt;
    logic        r_sign;
    logic        r_run;
    logic        r_first;
    logic [N-1:0] r_out;
    logic        r_done;
    logic        r_busy;

    logic        w_sat_hi;
    logic        w_sat_lo;
    logic [4:0]  w_len;
    logic        w_rbit;
    logic [30:0] w_payload;
    logic        w_unused_hidden;

    assign w_unused_hidden = mantissa[31];

    // Saturation ranges of a 6-bit k: {30,31} and {-32,-31}.
    assign w_sat_hi = ~k[K_W-1] & (&k[K_W-2:1]);
    assign w_sat_lo =  k[K_W-1] & ~(|k[K_W-2:1]);

    // k>=0: k+2 ; k<0: -k+1 = ~k+2. Non-saturated values fit in 5 bits.
    assign w_len = (k[K_W-1] ? ~k[4:0] : k[4:0]) + 5'd2;

    // Shifting right places the first inserted bit lowest, so the terminator
    // goes in first and the run bits follow it.
    assign w_rbit = r_first ? ~r_run : r_run;

    posit_round_rne u_round (
        .i_body    (r_body),
        .o_payload (w_payload)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_body  <= '0;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_run   <= 1'b0;
            r_first <= 1'b0;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sign <= sign;
                        r_busy <= 1'b1;
                        if (NAR) begin
                            r_out   <= NAR_PAT;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else if (ZERO) begin
                            r_out   <= '0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else if (w_sat_hi) begin
                            r_out   <= sign ? (32'd0 - MAXPOS) : MAXPOS;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else if (w_sat_lo) begin
                            r_out   <= sign ? (32'd0 - MINPOS) : MINPOS;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_body  <= {exp_value, mantissa[30:0], 30'b0};
                            r_cnt   <= w_len;
                            r_run   <= ~k[K_W-1];
                            r_first <= 1'b1;
                            r_state <= REGIME;
                        end
                    end
                end
                REGIME: begin
                    r_body  <= {w_rbit, r_body[63:1]};
                    r_first <= 1'b0;
                    r_cnt   <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    r_out   <= r_sign ? (32'd0 - {1'b0, w_payload})
                                      : {1'b0, w_payload};
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    if (received) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign posit_out = r_out;
    assign done      = r_done;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_posit_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_posit_encoder
// Description : Directed self-checking bench for posit_encoder with a
//               scoreboard queue of expected words and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_posit_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        received = 1'b0;
    logic        sign = 1'b0;
    logic [5:0]  k = '0;
    logic [2:0]  exp_value = '0;
    logic [31:0] mantissa = '0;
    logic        ZERO = 1'b0;
    logic        NAR = 1'b0;
    logic [31:0] posit_out;
    logic        done;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
        int          lat;
    } exp_t;

    exp_t sb[$];

    posit_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .received  (received),
        .sign      (sign),
        .k         (k),
        .exp_value (exp_value),
        .mantissa  (mantissa),
        .ZERO      (ZERO),
        .NAR       (NAR),
        .posit_out (posit_out),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one request, wait for done (bounded), compare against the scoreboard,
    // optionally hold off the ack, then acknowledge.
    task automatic run_case(input string tag, input bit s, input int kv,
                            input logic [2:0] e, input logic [31:0] m,
                            input bit z, input bit n,
                            input logic [31:0] ev, input int el,
                            input int hold, input int pulse_at);
        exp_t item;
        int   lat;
        logic [5:0] kk;
        kk = kv[5:0];
        @(negedge clk);
        sign = s; k = kk; exp_value = e; mantissa = m; ZERO = z; NAR = n;
        start = 1'b1;
        sb.push_back('{tag, ev, el});
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        check({tag, " busy"}, {31'b0, busy}, 32'd1);
        while (!done && lat < 60) begin
            if (pulse_at != 0 && lat == pulse_at) begin
                start = 1'b1; NAR = 1'b1; sign = ~s; k = 6'd1;
            end
            @(posedge clk); #1;
            start = 1'b0; NAR = n; sign = s; k = kk;
            lat++;
        end
        item = sb.pop_front();
        check({item.tag, " value"}, posit_out, item.val);
        check({item.tag, " latency"}, 32'(lat), 32'(item.lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({item.tag, " hold"}, {posit_out[31:1], posit_out[0] & done},
                  {item.val[31:1], item.val[0] & 1'b1});
            check({item.tag, " hold done"}, {31'b0, done}, 32'd1);
        end
        received = 1'b1;
        @(posedge clk); #1;
        received = 1'b0;
        check({item.tag, " ack done"}, {30'b0, done, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check("reset posit_out", posit_out, 32'h0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_case("one",      1'b0, 0,   3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h4000_0000, 4, 0, 0);
        run_case("minusone", 1'b1, 0,   3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'hC000_0000, 4, 0, 0);
        run_case("nar",      1'b0, 0,   3'd0, 32'h8000_0000, 1'b1, 1'b1, 32'h8000_0000, 1, 0, 0);
        run_case("zero",     1'b1, 3,   3'd2, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0000, 1, 0, 0);
        run_case("maxpos",   1'b0, 30,  3'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF, 1, 0, 0);
        run_case("minpos",   1'b0, -31, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0001, 1, 0, 0);
        run_case("negmax",   1'b1, 30,  3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0001, 1, 0, 0);
        run_case("negmin",   1'b1, -32, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 1, 0, 0);
        run_case("rne tie",  1'b0, 0,   3'd0, 32'h8000_0010, 1'b0, 1'b0, 32'h4000_0000, 4, 0, 0);
        run_case("rne odd",  1'b0, 0,   3'd0, 32'h8000_0030, 1'b0, 1'b0, 32'h4000_0002, 4, 0, 0);
        run_case("rne stk",  1'b0, 0,   3'd0, 32'h8000_0011, 1'b0, 1'b0, 32'h4000_0001, 4, 0, 0);
        run_case("k5",       1'b0, 5,   3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h7E00_0000, 9, 0, 0);
        run_case("km4",      1'b0, -4,  3'd5, 32'h8000_0000, 1'b0, 1'b0, 32'h0680_0000, 7, 0, 0);
        run_case("carry",    1'b0, 0,   3'd7, 32'hFFFF_FFF0, 1'b0, 1'b0, 32'h6000_0000, 4, 0, 0);
        run_case("hold",     1'b1, -4,  3'd5, 32'h8000_0000, 1'b0, 1'b0, 32'hF980_0000, 7, 20, 0);
        run_case("midstart", 1'b0, 5,   3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h7E00_0000, 9, 0, 3);

        // Reset in the middle of REGIME must clear outputs immediately.
        @(negedge clk);
        sign = 1'b0; k = 6'd5; exp_value = 3'd0; mantissa = 32'h8000_0000;
        ZERO = 1'b0; NAR = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst posit_out", posit_out, 32'h0);
        check("midrst flags", {30'b0, done, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_case("after rst", 1'b0, 0, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h4000_0000, 4, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
